normal_estimation: RTL
======================

NORMAL_ESTIMATION -- requirements
Module: normal_estimation

Interface
REQ-001 SHALL import RgbdVoConfigPk and use CLOUD_BW (point width) and MUL (fractional bits); normal width NW = CLOUD_BW+CLOUD_BW-MUL.
REQ-002 SHALL have parameters: H_SIZE, default 640, pixels per row; V_SIZE, default 480, rows per frame.
REQ-003 SHALL have ports:
- i_clk  in  1  sole clock, rising edge
- i_rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- i_valid  in  1  input point valid
- i_sof  in  1  first pixel of frame, qualified by i_valid
- i_point_x/y/z  in  CLOUD_BW each  signed fixed-point 3D point, raster order
- o_ready  out  1  input accepted when i_valid && o_ready
- o_valid  out  1  output normal valid
- o_sof  out  1  marks output for pixel (0,0)
- o_normal_x/y/z  out  NW each  signed unnormalized normal, feeds the normal unitization stage directly

Function
REQ-004 SHALL keep column counter c (0..H_SIZE-1) and row counter r (0..V_SIZE-1) advanced once per accepted input; c wraps to 0 and r increments at c=H_SIZE-1.
REQ-005 SHALL store the two most recent complete rows in two H_SIZE-deep line buffers (3*CLOUD_BW per entry); write of current pixel and read of same column SHALL return the previous-row value (read-before-write).
REQ-006 SHALL, for accepted input (r,c) with r>=1, compute the normal of center pixel (r-1,c) using up=(r-2,c), down=(r,c), left=(r-1,c-1), right=(r-1,c+1).
REQ-007 SHALL form du=right-left, dv=down-up at CLOUD_BW+1 bits signed, no overflow.
REQ-008 SHALL compute n=du x dv (n_x=du_y*dv_z-du_z*dv_y, cyclic), full-precision, then arithmetic shift right by MUL, then saturate to signed NW range [-2^(NW-1), 2^(NW-1)-1].
REQ-009 SHALL output zero normal when center is on a border (r-1=0, r-1=V_SIZE-1, c=0, c=H_SIZE-1) or when center, up, down, left or right has z==0.
REQ-010 SHALL produce o_valid exactly 4 cycles after the accepting clock edge, fixed, one output per accepted input with r>=1; no output for inputs of row 0.
REQ-011 SHALL implement states FILL (row 0 being received, no outputs), RUN (rows 1..V_SIZE-1), FLUSH.
REQ-012 SHALL transition FILL->RUN on acceptance of (0,H_SIZE-1); RUN->FLUSH on acceptance of (V_SIZE-1,H_SIZE-1); FLUSH->FILL after H_SIZE flush cycles.
REQ-013 SHALL, in FLUSH, hold o_ready=0 for exactly H_SIZE cycles and inject H_SIZE internal zero-normal outputs for row V_SIZE-1, columns 0..H_SIZE-1, one per cycle, through the same 4-cycle pipeline; total outputs per frame = H_SIZE*V_SIZE.
REQ-014 SHALL hold o_ready=1 in FILL and RUN; o_ready SHALL be a register output.
REQ-015 SHALL, on accepted input with i_sof=1 in any state, force counters to (0,0), state to FILL, treat the pixel as (0,0); outputs already in the pipeline SHALL still drain; abandoned frame SHALL NOT be flushed.
REQ-016 SHALL assert o_sof together with the output of pixel (0,0) only.
REQ-017 SHALL drive o_normal_* to 0 whenever o_valid=0.
REQ-018 SHALL tolerate i_valid gaps of any length in FILL/RUN with no change to counters, state or pipeline contents other than draining.

Reset
REQ-019 SHALL, on i_rst_n low, asynchronously set state FILL, counters (0,0), o_ready=1, o_valid=0, o_sof=0, o_normal_*=0, and clear all pipeline valid bits; line buffer contents need not be reset.
REQ-020 SHALL discard any partial frame and pending flush on reset; first accepted pixel after reset is (0,0).

Verification (H_SIZE=8, V_SIZE=6)
REQ-021 Plane: x=c<<MUL, y=r<<MUL, z=5<<MUL, continuous valid -> 48 outputs; interior pixels (1..4,1..6) = (0,0,4<<MUL); all border pixels (0,0,0); o_sof on first output only.
REQ-022 Latency/flush: last pixel accepted at cycle T -> o_ready low cycles T+1..T+8; outputs 41..48 zero, last o_valid at T+12.
REQ-023 Saturation: right x=2^(CLOUD_BW-1)-1, left x=-2^(CLOUD_BW-1), down y=2^(CLOUD_BW-1)-1, up y=-2^(CLOUD_BW-1), all z equal nonzero -> n_z=2^(NW-1)-1.
REQ-024 Invalid depth: plane of REQ-021 with pixel (2,3) z=0 -> normals of (1,3),(2,2),(2,3),(2,4),(3,3) zero, others unchanged.
REQ-025 Resync: i_sof asserted at pixel (3,5) of frame -> counters restart, no flush, next frame outputs identical to REQ-021.
REQ-026 Reset mid-RUN and mid-FLUSH -> outputs zero immediately, o_ready=1, following clean frame matches REQ-021.

Source files
------------

// File: rtl/normal_estimation.sv
// -----------------------------------------------------------------------------
// normal_estimation
//
// Estimates an unnormalised surface normal for every pixel of an organised
// point cloud. The cloud arrives in raster order, one point per accepted beat.
// Each normal is the cross product of two central differences:
//   du = right - left
//   dv = down  - up
// The raw product is scaled back by MUL fractional bits and then saturated.
// The normal of row r-1 is produced while row r is streaming in. The last row
// of a frame is emitted during a short flush, while input is held off.
//
// Ports
//   i_clk, i_rst_n          clock; asynchronous active-low reset
//   i_valid, i_sof          input point valid; first pixel of a frame
//   i_point_x/y/z           signed fixed-point point (CLOUD_BW bits each)
//   o_ready                 input accepted when i_valid && o_ready (registered)
//   o_valid, o_sof          normal valid; marks the normal of pixel (0,0)
//   o_normal_x/y/z          signed normal (NW bits), zero when o_valid = 0
// -----------------------------------------------------------------------------
package RgbdVoConfigPk;
  localparam int CLOUD_BW = 16;
  localparam int MUL      = 8;
  localparam int NW       = CLOUD_BW + CLOUD_BW - MUL;
endpackage

module normal_estimation
  import RgbdVoConfigPk::*;
#(
  parameter int H_SIZE = 640,
  parameter int V_SIZE = 480
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_valid,
  input  logic                       i_sof,
  input  logic signed [CLOUD_BW-1:0] i_point_x,
  input  logic signed [CLOUD_BW-1:0] i_point_y,
  input  logic signed [CLOUD_BW-1:0] i_point_z,
  output logic                       o_ready,
  output logic                       o_valid,
  output logic                       o_sof,
  output logic signed [NW-1:0]       o_normal_x,
  output logic signed [NW-1:0]       o_normal_y,
  output logic signed [NW-1:0]       o_normal_z
);

  localparam int CW = (H_SIZE > 1) ? $clog2(H_SIZE) : 1;
  localparam int RW = (V_SIZE > 1) ? $clog2(V_SIZE) : 1;
  localparam int DW = CLOUD_BW + 1;   // difference width, cannot overflow
  localparam int PW = 2 * DW;         // full-precision product
  localparam int XW = PW + 1;         // difference of two products

  localparam logic [CW-1:0] COL_LAST = CW'(H_SIZE - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(V_SIZE - 1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);

  typedef struct packed {
    logic signed [CLOUD_BW-1:0] x;
    logic signed [CLOUD_BW-1:0] y;
    logic signed [CLOUD_BW-1:0] z;
  } point_t;

  typedef struct packed {
    logic signed [DW-1:0] x;
    logic signed [DW-1:0] y;
    logic signed [DW-1:0] z;
  } diff_t;

  typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;

  // Difference a - b at one extra bit.
  function automatic diff_t point_diff(input point_t a, input point_t b);
    diff_t d;
    d.x = DW'(a.x) - DW'(b.x);
    d.y = DW'(a.y) - DW'(b.y);
    d.z = DW'(a.z) - DW'(b.z);
    return d;
  endfunction

  // Arithmetic shift right by MUL, then clamp into the signed NW range.
  function automatic logic signed [NW-1:0] shift_sat(input logic signed [XW-1:0] v);
    logic signed [XW-1:0] sh;
    logic [XW-NW:0]       hi;
    sh = v >>> MUL;
    hi = sh[XW-1:NW-1];
    if ((&hi) || !(|hi)) return sh[NW-1:0];
    else if (sh[XW-1])   return {1'b1, {(NW-1){1'b0}}};
    else                 return {1'b0, {(NW-1){1'b1}}};
  endfunction

  // line_cur holds row r-1 and line_old holds row r-2, indexed by column.
  point_t line_cur [H_SIZE];
  point_t line_old [H_SIZE];

  state_t        state_q, state_d;
  logic [CW-1:0] col_q, col_d, fcol_q, fcol_d;
  logic [RW-1:0] row_q, row_d;

  logic          accept, emit, flush_inject, border, depth_hole;
  logic [CW-1:0] eff_col, col_right;
  logic [RW-1:0] eff_row;
  point_t        down_p, center_p, up_p, right_p, left_q;

  // Pipeline: s1 neighbourhood, s2 differences, s3 products, s4 cross, o_*.
  logic                 s1_valid, s2_valid, s3_valid, s4_valid;
  logic                 s1_sof, s2_sof, s3_sof, s4_sof;
  logic                 s1_zero, s2_zero, s3_zero, s4_zero;
  point_t               s1_up, s1_down, s1_left, s1_right;
  diff_t                s2_du, s2_dv;
  logic signed [PW-1:0] s3_yz, s3_zy, s3_zx, s3_xz, s3_xy, s3_yx;
  logic signed [XW-1:0] s4_nx, s4_ny, s4_nz;

  assign accept = i_valid && o_ready;

  // A frame-start pixel is treated as (0,0), whatever the counters say.
  assign eff_col = i_sof ? '0 : col_q;
  assign eff_row = i_sof ? '0 : row_q;

  // At the last column, "right" is clamped. That pixel is a border pixel,
  // so the value read there is never used.
  assign col_right = (eff_col == COL_LAST) ? eff_col : eff_col + 1'b1;

  // Line-buffer reads happen before the write below, so both buffers
  // still hold the previous rows.
  assign down_p   = '{x: i_point_x, y: i_point_y, z: i_point_z};
  assign center_p = line_cur[eff_col];
  assign up_p     = line_old[eff_col];
  assign right_p  = line_cur[col_right];

  assign flush_inject = (state_q == FLUSH);
  assign emit         = accept && (eff_row != '0);

  // The centre is row eff_row-1. Its bottom-row case occurs only while
  // flushing, and every flushed output is forced to zero anyway.
  assign border     = (eff_row == ROW_ONE) || (eff_col == '0) || (eff_col == COL_LAST);
  assign depth_hole = (center_p.z == '0) || (up_p.z == '0) || (down_p.z == '0) ||
                      (left_q.z == '0) || (right_p.z == '0);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through it leaves a signal unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    fcol_d  = fcol_q;
    if (state_q == FLUSH) begin
      if (fcol_q == COL_LAST) begin
        state_d = FILL;
        fcol_d  = '0;
      end else begin
        fcol_d = fcol_q + 1'b1;
      end
    end else if (accept) begin
      if (eff_col == COL_LAST) begin
        col_d = '0;
        if (eff_row == ROW_LAST) begin
          row_d   = '0;
          state_d = FLUSH;
        end else begin
          row_d   = eff_row + 1'b1;
          state_d = RUN;
        end
      end else begin
        col_d   = eff_col + 1'b1;
        row_d   = eff_row;
        state_d = i_sof ? FILL : state_q;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only. Every
  // register then samples pre-edge values, whatever order the blocks
  // are evaluated in.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= FILL;
      col_q      <= '0;
      row_q      <= '0;
      fcol_q     <= '0;
      o_ready    <= 1'b1;
      s1_valid   <= 1'b0;
      s2_valid   <= 1'b0;
      s3_valid   <= 1'b0;
      s4_valid   <= 1'b0;
      s1_sof     <= 1'b0;
      s2_sof     <= 1'b0;
      s3_sof     <= 1'b0;
      s4_sof     <= 1'b0;
      s1_zero    <= 1'b0;
      s2_zero    <= 1'b0;
      s3_zero    <= 1'b0;
      s4_zero    <= 1'b0;
      o_valid    <= 1'b0;
      o_sof      <= 1'b0;
      o_normal_x <= '0;
      o_normal_y <= '0;
      o_normal_z <= '0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      fcol_q   <= fcol_d;
      o_ready  <= (state_d != FLUSH);

      s1_valid <= emit || flush_inject;
      s1_sof   <= emit && (eff_row == ROW_ONE) && (eff_col == '0);
      s1_zero  <= flush_inject || border || depth_hole;
      s2_valid <= s1_valid;
      s2_sof   <= s1_sof;
      s2_zero  <= s1_zero;
      s3_valid <= s2_valid;
      s3_sof   <= s2_sof;
      s3_zero  <= s2_zero;
      s4_valid <= s3_valid;
      s4_sof   <= s3_sof;
      s4_zero  <= s3_zero;

      o_valid  <= s4_valid;
      o_sof    <= s4_valid && s4_sof;
      if (s4_valid && !s4_zero) begin
        o_normal_x <= shift_sat(s4_nx);
        o_normal_y <= shift_sat(s4_ny);
        o_normal_z <= shift_sat(s4_nz);
      end else begin
        o_normal_x <= '0;
        o_normal_y <= '0;
        o_normal_z <= '0;
      end
    end
  end

  // NOTE: line buffers and datapath registers have no reset. The reset
  // valid/zero flags already mask anything stale, and leaving these
  // registers unreset allows the buffers to map onto RAM.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      line_cur[eff_col] <= down_p;
      line_old[eff_col] <= center_p;
      left_q            <= center_p;
    end
    s1_up    <= up_p;
    s1_down  <= down_p;
    s1_left  <= left_q;
    s1_right <= right_p;

    s2_du <= point_diff(s1_right, s1_left);
    s2_dv <= point_diff(s1_down, s1_up);

    s3_yz <= PW'(s2_du.y) * PW'(s2_dv.z);
    s3_zy <= PW'(s2_du.z) * PW'(s2_dv.y);
    s3_zx <= PW'(s2_du.z) * PW'(s2_dv.x);
    s3_xz <= PW'(s2_du.x) * PW'(s2_dv.z);
    s3_xy <= PW'(s2_du.x) * PW'(s2_dv.y);
    s3_yx <= PW'(s2_du.y) * PW'(s2_dv.x);

    s4_nx <= XW'(s3_yz) - XW'(s3_zy);
    s4_ny <= XW'(s3_zx) - XW'(s3_xz);
    s4_nz <= XW'(s3_xy) - XW'(s3_yx);
  end

endmodule
